// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types for the multicycle RV32I control FSM: states, opcodes and the
// datapath select encodings that the FSM drives.
package multicycle_control_fsm_pkg;

  typedef enum logic [1:0] {
    ALU_OP__ADD                = 2'b00,
    ALU_OP__BRANCH             = 2'b01,
    ALU_OP__REGISTER_OPERATION = 2'b10,
    ALU_OP__UNSET              = 2'b11
  } alu_op_t;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADR,
    ST_MEM_READ,
    ST_MEM_WB,
    ST_MEM_WRITE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_LUI,
    ST_AUIPC,
    ST_ALU_WB,
    ST_JAL,
    ST_JALR,
    ST_JALR_PC,
    ST_BRANCH,
    ST_TRAP
  } ctrl_state_t;

  typedef enum logic [1:0] {
    RS_ALU_OUT    = 2'b00,
    RS_MEM_DATA   = 2'b01,
    RS_ALU_RESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'b00,
    SRC_A_OLD_PC = 2'b01,
    SRC_A_RS1    = 2'b10,
    SRC_A_ZERO   = 2'b11
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } alu_src_b_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // States that hold a memory request open and therefore feed the timeout counter.
  function automatic logic is_mem_wait(input ctrl_state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle datapath (master) and its control FSM (slave).
interface multicycle_control_fsm_if;
  import multicycle_control_fsm_pkg::*;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;

  // mem_read/mem_write stay high until mem_ready is sampled high on a rising
  // edge; that edge completes the transfer. mem_ready is ignored otherwise.
  logic        pc_write;
  logic        adr_src;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  result_src_t result_src;
  alu_src_a_t  alu_src_a;
  alu_src_b_t  alu_src_b;
  alu_op_t     alu_op;
  logic        illegal_instr;
  logic        mem_timeout;

  modport master (
    output opcode, funct3, zero, mem_ready,
    input  pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, alu_op, illegal_instr, mem_timeout
  );

  modport slave (
    input  opcode, funct3, zero, mem_ready,
    output pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
    output result_src, alu_src_a, alu_src_b, alu_op, illegal_instr, mem_timeout
  );

endinterface

// File: rtl/multicycle_control_fsm_branch_cond.sv
// Branch-taken decision from funct3 and the ALU zero flag. For the 1xx class the
// ALU produces an SLT/SGE-style result, so "taken" means that result is nonzero.
module multicycle_control_fsm_branch_cond (
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    casez (funct3_i)
      3'b000:  taken_o = zero_i;
      3'b001:  taken_o = !zero_i;
      3'b1??:  taken_o = !zero_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences each instruction,
// drives datapath selects/enables and the memory request, and raises sticky traps.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.slave  bus,
  output ctrl_state_t              state_o,
  output logic [CNT_W-1:0]         tmo_cnt_o
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             tmo_q, tmo_d;
  logic             taken;
  logic             waiting;
  logic             cnt_hit;
  logic [CNT_W-1:0] cnt_inc;

  multicycle_control_fsm_branch_cond u_branch_cond (
    .funct3_i (bus.funct3),
    .zero_i   (bus.zero),
    .taken_o  (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      tmo_q     <= tmo_d;
    end
  end

  // A cycle with mem_ready high never counts, so a late ready beats the timeout.
  assign waiting = is_mem_wait(state_q) && !bus.mem_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign cnt_hit = (MEM_TIMEOUT != 0) && waiting && (cnt_inc == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      ST_FETCH:     if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (bus.opcode)
          OPC_LOAD, OPC_STORE: state_d = ST_MEM_ADR;
          OPC_OP:              state_d = ST_EXEC_R;
          OPC_OP_IMM:          state_d = ST_EXEC_I;
          OPC_JAL:             state_d = ST_JAL;
          OPC_JALR:            state_d = ST_JALR;
          OPC_BRANCH:          state_d = ST_BRANCH;
          OPC_LUI:             state_d = ST_LUI;
          OPC_AUIPC:           state_d = ST_AUIPC;
          default: begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_MEM_ADR:   state_d = (bus.opcode == OPC_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (bus.mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: if (bus.mem_ready) state_d = ST_FETCH;
      ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_AUIPC, ST_JAL, ST_JALR_PC:
                    state_d = ST_ALU_WB;
      ST_JALR:      state_d = ST_JALR_PC;
      ST_ALU_WB:    state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
    endcase
    if (cnt_hit) begin
      state_d = ST_TRAP;
      tmo_d   = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((MEM_TIMEOUT != 0) && waiting) begin
      cnt_d = cnt_inc;
    end
  end

  // Outputs fall back to idle values while reset is high so a request in
  // flight is withdrawn immediately rather than at the next edge.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = RS_ALU_OUT;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_RS2;
    bus.alu_op     = ALU_OP__ADD;
    if (!reset) begin
      unique case (state_q)
        ST_FETCH: begin
          bus.mem_read   = 1'b1;
          bus.alu_src_b  = SRC_B_FOUR;
          bus.result_src = RS_ALU_RESULT;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
        end
        ST_DECODE: begin
          bus.alu_src_a = SRC_A_OLD_PC;
          bus.alu_src_b = SRC_B_IMM;
        end
        ST_MEM_ADR, ST_JALR: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_src_b = SRC_B_IMM;
        end
        ST_MEM_READ: begin
          bus.adr_src  = 1'b1;
          bus.mem_read = 1'b1;
        end
        ST_MEM_WB: begin
          bus.result_src = RS_MEM_DATA;
          bus.reg_write  = 1'b1;
        end
        ST_MEM_WRITE: begin
          bus.adr_src   = 1'b1;
          bus.mem_write = 1'b1;
        end
        ST_EXEC_R: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_op    = ALU_OP__REGISTER_OPERATION;
        end
        ST_EXEC_I: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_src_b = SRC_B_IMM;
          bus.alu_op    = ALU_OP__UNSET;
        end
        ST_LUI: begin
          bus.alu_src_a = SRC_A_ZERO;
          bus.alu_src_b = SRC_B_IMM;
        end
        ST_AUIPC: begin
          bus.alu_src_a = SRC_A_OLD_PC;
          bus.alu_src_b = SRC_B_IMM;
        end
        ST_ALU_WB:      bus.reg_write = 1'b1;
        ST_JAL, ST_JALR_PC: begin
          bus.alu_src_a = SRC_A_OLD_PC;
          bus.alu_src_b = SRC_B_FOUR;
          bus.pc_write  = 1'b1;
        end
        ST_BRANCH: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_op    = ALU_OP__BRANCH;
          bus.pc_write  = taken;
        end
        default: ;
      endcase
    end
  end

  assign bus.illegal_instr = illegal_q;
  assign bus.mem_timeout   = tmo_q;
  assign state_o           = state_q;
  assign tmo_cnt_o         = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle control FSM: per-cycle vector table for each
// instruction class, plus hand-written trap, timeout and mid-transfer reset sequences.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_m;
  logic rst_a;

  multicycle_control_fsm_if bus_m ();
  multicycle_control_fsm_if bus4 ();
  multicycle_control_fsm_if bus0 ();

  ctrl_state_t st_m, st_4, st_0;
  logic [4:0]  cnt_m;
  logic [2:0]  cnt_4;
  logic [0:0]  cnt_0;

  multicycle_control_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(rst_m), .bus(bus_m), .state_o(st_m), .tmo_cnt_o(cnt_m));
  multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut4 (
    .clk(clk), .reset(rst_a), .bus(bus4), .state_o(st_4), .tmo_cnt_o(cnt_4));
  multicycle_control_fsm #(.MEM_TIMEOUT(0)) dut0 (
    .clk(clk), .reset(rst_a), .bus(bus0), .state_o(st_0), .tmo_cnt_o(cnt_0));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // ctl = {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src}
  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    ctrl_state_t st;
    logic [5:0]  ctl;
    result_src_t rs;
    alu_src_a_t  a;
    alu_src_b_t  b;
    alu_op_t     op;
  } vec_t;

  vec_t vecs[$];

  localparam result_src_t R0 = RS_ALU_OUT, R1 = RS_MEM_DATA, R2 = RS_ALU_RESULT;
  localparam alu_src_a_t  APC = SRC_A_PC, AOLD = SRC_A_OLD_PC, ARS1 = SRC_A_RS1, AZ = SRC_A_ZERO;
  localparam alu_src_b_t  BRS2 = SRC_B_RS2, BIMM = SRC_B_IMM, B4 = SRC_B_FOUR;
  localparam alu_op_t     ADD = ALU_OP__ADD, BR = ALU_OP__BRANCH;
  localparam alu_op_t     RG = ALU_OP__REGISTER_OPERATION, UN = ALU_OP__UNSET;

  function automatic void v(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                            input logic rdy, input ctrl_state_t st, input logic [5:0] ctl,
                            input result_src_t rs, input alu_src_a_t a, input alu_src_b_t b,
                            input alu_op_t op);
    vec_t t;
    t = '{opc, f3, z, rdy, st, ctl, rs, a, b, op};
    vecs.push_back(t);
  endfunction

  task automatic build_table();
    // add x3,x1,x2 (one memory stall in FETCH first)
    v(OPC_OP, 3'd0, 1'b0, 1'b0, ST_FETCH,     6'b000100, R2, APC,  B4,   ADD);
    v(OPC_OP, 3'd0, 1'b0, 1'b1, ST_FETCH,     6'b110100, R2, APC,  B4,   ADD);
    v(OPC_OP, 3'd0, 1'b0, 1'b1, ST_DECODE,    6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_OP, 3'd0, 1'b0, 1'b1, ST_EXEC_R,    6'b000000, R0, ARS1, BRS2, RG);
    v(OPC_OP, 3'd0, 1'b0, 1'b1, ST_ALU_WB,    6'b001000, R0, APC,  BRS2, ADD);
    // lw, memory stalls 3 cycles in MEM_READ
    v(OPC_LOAD, 3'd2, 1'b0, 1'b1, ST_FETCH,    6'b110100, R2, APC,  B4,   ADD);
    v(OPC_LOAD, 3'd2, 1'b0, 1'b1, ST_DECODE,   6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_LOAD, 3'd2, 1'b0, 1'b1, ST_MEM_ADR,  6'b000000, R0, ARS1, BIMM, ADD);
    v(OPC_LOAD, 3'd2, 1'b0, 1'b0, ST_MEM_READ, 6'b000101, R0, APC,  BRS2, ADD);
    v(OPC_LOAD, 3'd2, 1'b0, 1'b0, ST_MEM_READ, 6'b000101, R0, APC,  BRS2, ADD);
    v(OPC_LOAD, 3'd2, 1'b0, 1'b0, ST_MEM_READ, 6'b000101, R0, APC,  BRS2, ADD);
    v(OPC_LOAD, 3'd2, 1'b0, 1'b1, ST_MEM_READ, 6'b000101, R0, APC,  BRS2, ADD);
    v(OPC_LOAD, 3'd2, 1'b0, 1'b1, ST_MEM_WB,   6'b001000, R1, APC,  BRS2, ADD);
    // sw, one stall
    v(OPC_STORE, 3'd2, 1'b0, 1'b1, ST_FETCH,     6'b110100, R2, APC,  B4,   ADD);
    v(OPC_STORE, 3'd2, 1'b0, 1'b1, ST_DECODE,    6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_STORE, 3'd2, 1'b0, 1'b1, ST_MEM_ADR,   6'b000000, R0, ARS1, BIMM, ADD);
    v(OPC_STORE, 3'd2, 1'b0, 1'b0, ST_MEM_WRITE, 6'b000011, R0, APC,  BRS2, ADD);
    v(OPC_STORE, 3'd2, 1'b0, 1'b1, ST_MEM_WRITE, 6'b000011, R0, APC,  BRS2, ADD);
    // beq zero=1 (taken), bne zero=1 (not), bge zero=0 (taken), funct3=010 (never)
    v(OPC_BRANCH, 3'd0, 1'b1, 1'b1, ST_FETCH,  6'b110100, R2, APC,  B4,   ADD);
    v(OPC_BRANCH, 3'd0, 1'b1, 1'b1, ST_DECODE, 6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_BRANCH, 3'd0, 1'b1, 1'b1, ST_BRANCH, 6'b100000, R0, ARS1, BRS2, BR);
    v(OPC_BRANCH, 3'd1, 1'b1, 1'b1, ST_FETCH,  6'b110100, R2, APC,  B4,   ADD);
    v(OPC_BRANCH, 3'd1, 1'b1, 1'b1, ST_DECODE, 6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_BRANCH, 3'd1, 1'b1, 1'b1, ST_BRANCH, 6'b000000, R0, ARS1, BRS2, BR);
    v(OPC_BRANCH, 3'd5, 1'b0, 1'b1, ST_FETCH,  6'b110100, R2, APC,  B4,   ADD);
    v(OPC_BRANCH, 3'd5, 1'b0, 1'b1, ST_DECODE, 6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_BRANCH, 3'd5, 1'b0, 1'b1, ST_BRANCH, 6'b100000, R0, ARS1, BRS2, BR);
    v(OPC_BRANCH, 3'd2, 1'b0, 1'b1, ST_FETCH,  6'b110100, R2, APC,  B4,   ADD);
    v(OPC_BRANCH, 3'd2, 1'b0, 1'b1, ST_DECODE, 6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_BRANCH, 3'd2, 1'b0, 1'b1, ST_BRANCH, 6'b000000, R0, ARS1, BRS2, BR);
    // jal
    v(OPC_JAL, 3'd0, 1'b0, 1'b1, ST_FETCH,  6'b110100, R2, APC,  B4,   ADD);
    v(OPC_JAL, 3'd0, 1'b0, 1'b1, ST_DECODE, 6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_JAL, 3'd0, 1'b0, 1'b1, ST_JAL,    6'b100000, R0, AOLD, B4,   ADD);
    v(OPC_JAL, 3'd0, 1'b0, 1'b1, ST_ALU_WB, 6'b001000, R0, APC,  BRS2, ADD);
    // jalr
    v(OPC_JALR, 3'd0, 1'b0, 1'b1, ST_FETCH,   6'b110100, R2, APC,  B4,   ADD);
    v(OPC_JALR, 3'd0, 1'b0, 1'b1, ST_DECODE,  6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_JALR, 3'd0, 1'b0, 1'b1, ST_JALR,    6'b000000, R0, ARS1, BIMM, ADD);
    v(OPC_JALR, 3'd0, 1'b0, 1'b1, ST_JALR_PC, 6'b100000, R0, AOLD, B4,   ADD);
    v(OPC_JALR, 3'd0, 1'b0, 1'b1, ST_ALU_WB,  6'b001000, R0, APC,  BRS2, ADD);
    // lui, auipc, addi
    v(OPC_LUI,    3'd0, 1'b0, 1'b1, ST_FETCH,  6'b110100, R2, APC,  B4,   ADD);
    v(OPC_LUI,    3'd0, 1'b0, 1'b1, ST_DECODE, 6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_LUI,    3'd0, 1'b0, 1'b1, ST_LUI,    6'b000000, R0, AZ,   BIMM, ADD);
    v(OPC_LUI,    3'd0, 1'b0, 1'b1, ST_ALU_WB, 6'b001000, R0, APC,  BRS2, ADD);
    v(OPC_AUIPC,  3'd0, 1'b0, 1'b1, ST_FETCH,  6'b110100, R2, APC,  B4,   ADD);
    v(OPC_AUIPC,  3'd0, 1'b0, 1'b1, ST_DECODE, 6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_AUIPC,  3'd0, 1'b0, 1'b1, ST_AUIPC,  6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_AUIPC,  3'd0, 1'b0, 1'b1, ST_ALU_WB, 6'b001000, R0, APC,  BRS2, ADD);
    v(OPC_OP_IMM, 3'd0, 1'b0, 1'b1, ST_FETCH,  6'b110100, R2, APC,  B4,   ADD);
    v(OPC_OP_IMM, 3'd0, 1'b0, 1'b1, ST_DECODE, 6'b000000, R0, AOLD, BIMM, ADD);
    v(OPC_OP_IMM, 3'd0, 1'b0, 1'b1, ST_EXEC_I, 6'b000000, R0, ARS1, BIMM, UN);
    v(OPC_OP_IMM, 3'd0, 1'b0, 1'b1, ST_ALU_WB, 6'b001000, R0, APC,  BRS2, ADD);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_m(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                         input logic rdy);
    @(negedge clk);
    bus_m.opcode    = opc;
    bus_m.funct3    = f3;
    bus_m.zero      = z;
    bus_m.mem_ready = rdy;
    #1;
  endtask

  function automatic logic [5:0] ctl_m();
    return {bus_m.pc_write, bus_m.ir_write, bus_m.reg_write,
            bus_m.mem_read, bus_m.mem_write, bus_m.adr_src};
  endfunction

  task automatic check_vec(input int i, input vec_t e);
    chk($sformatf("v%0d.state", i),  32'(st_m),             32'(e.st));
    chk($sformatf("v%0d.ctl", i),    32'(ctl_m()),          32'(e.ctl));
    chk($sformatf("v%0d.res_src", i), 32'(bus_m.result_src), 32'(e.rs));
    chk($sformatf("v%0d.src_a", i),  32'(bus_m.alu_src_a),  32'(e.a));
    chk($sformatf("v%0d.src_b", i),  32'(bus_m.alu_src_b),  32'(e.b));
    chk($sformatf("v%0d.alu_op", i), 32'(bus_m.alu_op),     32'(e.op));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_m = 1'b1;
    rst_a = 1'b1;
    bus_m.opcode = OPC_OP; bus_m.funct3 = 3'd0; bus_m.zero = 1'b0; bus_m.mem_ready = 1'b1;
    bus4.opcode  = 7'd0;   bus4.funct3  = 3'd0; bus4.zero  = 1'b0; bus4.mem_ready  = 1'b0;
    bus0.opcode  = 7'd0;   bus0.funct3  = 3'd0; bus0.zero  = 1'b0; bus0.mem_ready  = 1'b0;
    build_table();
    #1;
    // reset state: idle outputs even though FETCH is entered and mem_ready is high
    chk("rst.state",     32'(st_m),                32'(ST_FETCH));
    chk("rst.cnt",       32'(cnt_m),               32'd0);
    chk("rst.ctl",       32'(ctl_m()),             32'd0);
    chk("rst.src_b",     32'(bus_m.alu_src_b),     32'(SRC_B_RS2));
    chk("rst.res_src",   32'(bus_m.result_src),    32'(RS_ALU_OUT));
    chk("rst.illegal",   32'(bus_m.illegal_instr), 32'd0);
    chk("rst.timeout",   32'(bus_m.mem_timeout),   32'd0);
    @(negedge clk);
    bus_m.mem_ready = 1'b0;
    rst_m = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_m(vecs[i].opc, vecs[i].f3, vecs[i].z, vecs[i].rdy);
      check_vec(i, vecs[i]);
    end
    drive_m(7'h7F, 3'd0, 1'b0, 1'b1);
    chk("tbl.illegal", 32'(bus_m.illegal_instr), 32'd0);
    chk("tbl.timeout", 32'(bus_m.mem_timeout),   32'd0);

    // illegal opcode: FETCH was just applied, then DECODE, then TRAP forever
    chk("ill.fetch", 32'(st_m), 32'(ST_FETCH));
    drive_m(7'h7F, 3'd0, 1'b0, 1'b1);
    chk("ill.decode",      32'(st_m),                32'(ST_DECODE));
    chk("ill.flag_early",  32'(bus_m.illegal_instr), 32'd0);
    drive_m(7'h7F, 3'd0, 1'b0, 1'b1);
    chk("ill.trap",        32'(st_m),                32'(ST_TRAP));
    chk("ill.flag",        32'(bus_m.illegal_instr), 32'd1);
    chk("ill.no_timeout",  32'(bus_m.mem_timeout),   32'd0);
    for (int k = 0; k < 4; k++) begin
      drive_m(OPC_STORE, 3'd2, 1'b1, 1'b1);
      chk($sformatf("ill.hold%0d.state", k), 32'(st_m),                32'(ST_TRAP));
      chk($sformatf("ill.hold%0d.ctl", k),   32'(ctl_m()),             32'd0);
      chk($sformatf("ill.hold%0d.flag", k),  32'(bus_m.illegal_instr), 32'd1);
    end
    @(negedge clk);
    rst_m = 1'b1;
    bus_m.mem_ready = 1'b0;
    #1;
    chk("ill.rst_flag",  32'(bus_m.illegal_instr), 32'd0);
    chk("ill.rst_state", 32'(st_m),                32'(ST_FETCH));
    @(negedge clk);
    rst_m = 1'b0;

    // reset asserted mid-store: mem_write must drop without waiting for a clock
    drive_m(OPC_STORE, 3'd2, 1'b0, 1'b1);
    drive_m(OPC_STORE, 3'd2, 1'b0, 1'b1);
    drive_m(OPC_STORE, 3'd2, 1'b0, 1'b1);
    chk("rsw.mem_adr", 32'(st_m), 32'(ST_MEM_ADR));
    drive_m(OPC_STORE, 3'd2, 1'b0, 1'b0);
    chk("rsw.mw1",  32'(bus_m.mem_write), 32'd1);
    chk("rsw.cnt0", 32'(cnt_m),           32'd0);
    drive_m(OPC_STORE, 3'd2, 1'b0, 1'b0);
    chk("rsw.state", 32'(st_m),           32'(ST_MEM_WRITE));
    chk("rsw.cnt1",  32'(cnt_m),          32'd1);
    #2;
    rst_m = 1'b1;
    #1;
    chk("rsw.mw_drop",  32'(bus_m.mem_write), 32'd0);
    chk("rsw.mr_drop",  32'(bus_m.mem_read),  32'd0);
    chk("rsw.rw",       32'(bus_m.reg_write), 32'd0);
    chk("rsw.st_rst",   32'(st_m),            32'(ST_FETCH));
    chk("rsw.cnt_rst",  32'(cnt_m),           32'd0);
    @(negedge clk);
    rst_m = 1'b0;
    #1;
    chk("rsw.st_after",  32'(st_m),           32'(ST_FETCH));
    chk("rsw.cnt_after", 32'(cnt_m),          32'd0);
    chk("rsw.mr_after",  32'(bus_m.mem_read), 32'd1);

    // MEM_TIMEOUT=4: four stalled FETCH cycles, then TRAP
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("tmo.c%0d.state", k), 32'(st_4),             32'(ST_FETCH));
      chk($sformatf("tmo.c%0d.cnt", k),   32'(cnt_4),            32'(k));
      chk($sformatf("tmo.c%0d.flag", k),  32'(bus4.mem_timeout), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("tmo.trap",    32'(st_4),               32'(ST_TRAP));
    chk("tmo.flag",    32'(bus4.mem_timeout),   32'd1);
    chk("tmo.mr",      32'(bus4.mem_read),      32'd0);
    chk("tmo.illegal", 32'(bus4.illegal_instr), 32'd0);
    @(negedge clk);
    bus4.mem_ready = 1'b1;
    #1;
    chk("tmo.sticky_state", 32'(st_4),             32'(ST_TRAP));
    chk("tmo.sticky_flag",  32'(bus4.mem_timeout), 32'd1);

    // ready arriving on the would-be timeout cycle wins
    @(negedge clk);
    rst_a = 1'b1;
    bus4.mem_ready = 1'b0;
    #1;
    chk("win.rst_flag", 32'(bus4.mem_timeout), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("win.c%0d.cnt", k), 32'(cnt_4), 32'(k));
      @(negedge clk);
    end
    bus4.mem_ready = 1'b1;
    #1;
    chk("win.cnt3",  32'(cnt_4),          32'd3);
    chk("win.irw",   32'(bus4.ir_write),  32'd1);
    chk("win.fetch", 32'(st_4),           32'(ST_FETCH));
    @(negedge clk);
    bus4.mem_ready = 1'b0;
    #1;
    chk("win.decode", 32'(st_4),             32'(ST_DECODE));
    chk("win.flag",   32'(bus4.mem_timeout), 32'd0);
    chk("win.cnt",    32'(cnt_4),            32'd0);

    // MEM_TIMEOUT=0: stalled since the last aux reset release, never traps
    repeat (40) @(negedge clk);
    #1;
    chk("off.state", 32'(st_0),             32'(ST_FETCH));
    chk("off.flag",  32'(bus0.mem_timeout), 32'd0);
    chk("off.mr",    32'(bus0.mem_read),    32'd1);
    chk("off.cnt",   32'(cnt_0),            32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
